// File: rtl/conv_window_controller.sv
// conv_window_controller
//
// Frame-level sequencer in front of an Image_Buffer line-buffer/window generator.
// A frame runs IDLE -> CLEAR -> LOAD -> DRAIN -> DONE -> IDLE.
//   - CLEAR pulses the buffer's active-low clear for one cycle.
//   - LOAD accepts raw pixels and forwards them to the buffer.
//   - DRAIN waits for the buffer to emit its final window.
//   - DONE issues a one-cycle frame_done.
// Every buffer out_valid is tagged with the raster position of its newest pixel.
// Only pulses that correspond to a complete, stride-aligned KxK window are
// reported as win_valid, together with the window's top-left coordinate.
//
// Ports:
//   clock, sreset_n         system clock; asynchronous active-low reset
//   start                   begin a frame; sampled only in IDLE
//   s_data/s_valid/s_ready  source pixel stream (valid/ready handshake)
//   ib_data/ib_data_valid   pixel forwarded to the buffer, one cycle after accept
//   ib_sreset_n             active-low clear to the buffer
//   ib_out_valid            buffer window pulse (one per pixel from row K-1 on)
//   win_valid               current buffer window is a legal convolution window
//   win_row/win_col         top-left coordinate of that window (held otherwise)
//   busy                    high in any state other than IDLE
//   frame_done              one-cycle pulse at the end of a frame
module conv_window_controller #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ROW_SIZE    = 28,
  parameter int COLUMN_SIZE = 28,
  parameter int STRIDE      = 1
) (
  input  logic                           clock,
  input  logic                           sreset_n,
  input  logic                           start,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  output logic                           s_ready,
  output logic [DATA_WIDTH-1:0]          ib_data,
  output logic                           ib_data_valid,
  output logic                           ib_sreset_n,
  input  logic                           ib_out_valid,
  output logic                           win_valid,
  output logic [$clog2(COLUMN_SIZE)-1:0] win_row,
  output logic [$clog2(ROW_SIZE)-1:0]    win_col,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int RW = $clog2(COLUMN_SIZE);
  localparam int CW = $clog2(ROW_SIZE);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [RW-1:0] ROW_FIRST  = RW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(COLUMN_SIZE - 1);
  localparam logic [CW-1:0] COL_FIRST  = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(ROW_SIZE - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(STRIDE - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, DONE} state_t;

  state_t        state;
  logic [RW-1:0] in_row;
  logic [CW-1:0] in_col;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic [PW-1:0] row_phase;
  logic [PW-1:0] col_phase;
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;
  logic          last_seen;

  logic accept;
  logic tracking;
  logic out_fire;
  logic out_last;

  // Control outputs are decoded straight from the state register.
  assign s_ready    = (state == LOAD);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  assign accept   = s_valid && s_ready;
  assign tracking = (state == LOAD) || (state == DRAIN);
  assign out_fire = ib_out_valid && tracking;
  assign out_last = out_fire && (out_row == ROW_LAST) && (out_col == COL_LAST);

  // col_phase is held at 0 until out_col reaches K-1. Both phases are therefore
  // the stride remainder of the window's top-left coordinate.
  assign win_valid = out_fire && (out_col >= COL_FIRST) &&
                     (row_phase == '0) && (col_phase == '0);

  // Coordinates are presented in the same cycle as win_valid and then held.
  assign win_row = win_valid ? (out_row - ROW_FIRST) : win_row_q;
  assign win_col = win_valid ? (out_col - COL_FIRST) : win_col_q;

  always_ff @(posedge clock or negedge sreset_n) begin
    if (!sreset_n) begin
      state         <= IDLE;
      in_row        <= '0;
      in_col        <= '0;
      out_row       <= '0;
      out_col       <= '0;
      row_phase     <= '0;
      col_phase     <= '0;
      win_row_q     <= '0;
      win_col_q     <= '0;
      last_seen     <= 1'b0;
      ib_data       <= '0;
      ib_data_valid <= 1'b0;
      ib_sreset_n   <= 1'b0;
    end else begin
      ib_sreset_n   <= 1'b1;
      ib_data_valid <= 1'b0;
      win_row_q     <= win_row;
      win_col_q     <= win_col;

      case (state)
        IDLE: begin
          if (start) begin
            state       <= CLEAR;
            ib_sreset_n <= 1'b0;   // low for exactly the CLEAR cycle
          end
        end
        CLEAR: begin
          in_row    <= '0;
          in_col    <= '0;
          out_row   <= ROW_FIRST;  // first buffer pulse belongs to row K-1
          out_col   <= '0;
          row_phase <= '0;
          col_phase <= '0;
          last_seen <= 1'b0;
          state     <= LOAD;
        end
        LOAD: begin
          if (accept) begin
            ib_data       <= s_data;
            ib_data_valid <= 1'b1;
            if (in_col == COL_LAST) begin
              in_col <= '0;
              in_row <= in_row + RW'(1);
              if (in_row == ROW_LAST) begin
                state <= DRAIN;
              end
            end else begin
              in_col <= in_col + CW'(1);
            end
          end
        end
        DRAIN: begin
          // last_seen covers a buffer fast enough to finish while still in LOAD.
          if (out_last || last_seen) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (out_fire) begin
        if (out_last) begin
          last_seen <= 1'b1;
        end
        if (out_col == COL_LAST) begin
          out_col   <= '0;
          col_phase <= '0;
          out_row   <= out_row + RW'(1);
          row_phase <= (row_phase == PHASE_LAST) ? '0 : row_phase + PW'(1);
        end else begin
          out_col <= out_col + CW'(1);
          if (out_col >= COL_FIRST) begin
            col_phase <= (col_phase == PHASE_LAST) ? '0 : col_phase + PW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_controller.sv
module tb_conv_window_controller;

  logic clock = 1'b0;
  logic sreset_n = 1'b0;
  always #5 clock = ~clock;

  // Inputs: index 0 drives the 4x4/stride-1 DUT, index 1 drives the 5x5/stride-2 DUT.
  logic       start_a   [2];
  logic       s_valid_a [2];
  logic [7:0] s_data_a  [2];

  logic       s_ready0, ibv0, ibsr0, ibov0, winv0, busy0, fd0;
  logic [7:0] ibd0;
  logic [1:0] wr0, wc0;
  logic       s_ready1, ibv1, ibsr1, ibov1, winv1, busy1, fd1;
  logic [7:0] ibd1;
  logic [2:0] wr1, wc1;

  conv_window_controller #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .ROW_SIZE(4),
                           .COLUMN_SIZE(4), .STRIDE(1)) dut0 (
    .clock(clock), .sreset_n(sreset_n), .start(start_a[0]),
    .s_data(s_data_a[0]), .s_valid(s_valid_a[0]), .s_ready(s_ready0),
    .ib_data(ibd0), .ib_data_valid(ibv0), .ib_sreset_n(ibsr0),
    .ib_out_valid(ibov0), .win_valid(winv0), .win_row(wr0), .win_col(wc0),
    .busy(busy0), .frame_done(fd0));

  conv_window_controller #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .ROW_SIZE(5),
                           .COLUMN_SIZE(5), .STRIDE(2)) dut1 (
    .clock(clock), .sreset_n(sreset_n), .start(start_a[1]),
    .s_data(s_data_a[1]), .s_valid(s_valid_a[1]), .s_ready(s_ready1),
    .ib_data(ibd1), .ib_data_valid(ibv1), .ib_sreset_n(ibsr1),
    .ib_out_valid(ibov1), .win_valid(winv1), .win_row(wr1), .win_col(wc1),
    .busy(busy1), .frame_done(fd1));

  // Behavioural Image_Buffer: one out_valid per forwarded pixel from index
  // (K-1)*ROW_SIZE on, one cycle after the pixel arrives.
  int bcnt0, bcnt1;
  always @(posedge clock or negedge sreset_n) begin
    if (!sreset_n || !ibsr0) begin
      bcnt0 <= 0; ibov0 <= 1'b0;
    end else begin
      ibov0 <= ibv0 && (bcnt0 >= 2 * 4);
      if (ibv0) bcnt0 <= bcnt0 + 1;
    end
  end
  always @(posedge clock or negedge sreset_n) begin
    if (!sreset_n || !ibsr1) begin
      bcnt1 <= 0; ibov1 <= 1'b0;
    end else begin
      ibov1 <= ibv1 && (bcnt1 >= 2 * 5);
      if (ibv1) bcnt1 <= bcnt1 + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int win_log [2][16];
  int win_n  [2];
  int fd_n   [2];
  int clr_n  [2];
  int out_n  [2];
  int last_out_cyc [2];
  int fd_cyc [2];

  always @(negedge clock) begin
    if (sreset_n) begin
      if (winv0) begin
        if (win_n[0] < 16) win_log[0][win_n[0]] = int'(wr0) * 16 + int'(wc0);
        win_n[0]++;
      end
      if (fd0) begin fd_n[0]++; fd_cyc[0] = cyc; end
      if (!ibsr0) clr_n[0]++;
      if (ibov0 && busy0) begin out_n[0]++; last_out_cyc[0] = cyc; end
      if (winv1) begin
        if (win_n[1] < 16) win_log[1][win_n[1]] = int'(wr1) * 16 + int'(wc1);
        win_n[1]++;
      end
      if (fd1) begin fd_n[1]++; fd_cyc[1] = cyc; end
      if (!ibsr1) clr_n[1]++;
      if (ibov1 && busy1) begin out_n[1]++; last_out_cyc[1] = cyc; end
    end
  end

  function automatic logic rdy(int s);  return s ? s_ready1 : s_ready0; endfunction
  function automatic logic dv(int s);   return s ? ibv1 : ibv0;          endfunction
  function automatic int   dat(int s);  return s ? int'(ibd1) : int'(ibd0); endfunction
  function automatic logic bsy(int s);  return s ? busy1 : busy0;        endfunction
  function automatic logic fdn(int s);  return s ? fd1 : fd0;            endfunction
  function automatic logic isr(int s);  return s ? ibsr1 : ibsr0;        endfunction

  task automatic clear_stats(int s);
    win_n[s] = 0; fd_n[s] = 0; clr_n[s] = 0; out_n[s] = 0;
  endtask

  task automatic pulse_start(int s);
    @(posedge clock); #1 start_a[s] = 1'b1;
    @(posedge clock); #1 start_a[s] = 1'b0;
  endtask

  // Offers one pixel, waits for the accept, and checks the forwarded copy.
  task automatic feed_pixel(int s, int p, bit stall);
    int n;
    s_data_a[s] = 8'(p);
    s_valid_a[s] = 1'b1;
    n = 0;
    while (!rdy(s) && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL accept_timeout pixel=%0d s_ready stayed 0, required 1", p);
    end
    @(posedge clock); #1;
    s_valid_a[s] = 1'b0;
    checks++;
    if (dv(s) !== 1'b1 || dat(s) !== p) begin
      errors++;
      $display("FAIL forward pixel=%0d got valid=%b data=%0d, required valid=1 data=%0d",
               p, dv(s), dat(s), p);
    end
    if (stall) begin
      @(posedge clock); #1;
      checks++;
      if (dv(s) !== 1'b0 || dat(s) !== p) begin
        errors++;
        $display("FAIL stall_gap pixel=%0d got valid=%b data=%0d, required valid=0 data=%0d",
                 p, dv(s), dat(s), p);
      end
    end
  endtask

  // Waits for frame_done; optionally pokes start on the DONE cycle.
  task automatic wait_done(int s, bit poke);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (fdn(s)) begin
        seen = 1;
        checks++;
        if (bsy(s) !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_done got %b, required 1", bsy(s));
        end
        if (poke) start_a[s] = 1'b1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout frame_done never seen, required one pulse");
    end
    @(posedge clock); #1 start_a[s] = 1'b0;
    @(negedge clock);
    checks++;
    if (bsy(s) !== 1'b0 || fdn(s) !== 1'b0 || isr(s) !== 1'b1) begin
      errors++;
      $display("FAIL after_done got busy=%b done=%b ib_sreset_n=%b, required 0 0 1",
               bsy(s), fdn(s), isr(s));
    end
  endtask

  task automatic check_frame(int s, string tag);
    int e[4];
    int outs;
    if (s == 0) begin e = '{0, 1, 16, 17}; outs = 8;  end
    else        begin e = '{0, 2, 32, 34}; outs = 15; end
    checks++;
    if (win_n[s] !== 4) begin
      errors++;
      $display("FAIL %s win_count got %0d, required 4", tag, win_n[s]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (win_log[s][i] !== e[i]) begin
        errors++;
        $display("FAIL %s win%0d got (%0d,%0d), required (%0d,%0d)", tag, i,
                 win_log[s][i] / 16, win_log[s][i] % 16, e[i] / 16, e[i] % 16);
      end
    end
    checks++;
    if (fd_n[s] !== 1 || clr_n[s] !== 1 || out_n[s] !== outs) begin
      errors++;
      $display("FAIL %s counts got done=%0d clear=%0d outs=%0d, required 1 1 %0d",
               tag, fd_n[s], clr_n[s], out_n[s], outs);
    end
    checks++;
    if (fd_cyc[s] - last_out_cyc[s] !== 1) begin
      errors++;
      $display("FAIL %s done_latency got %0d, required 1", tag, fd_cyc[s] - last_out_cyc[s]);
    end
  endtask

  task automatic run_frame(int s, bit stall, bit poke, string tag);
    int npix;
    npix = s ? 25 : 16;
    clear_stats(s);
    pulse_start(s);
    for (int p = 1; p <= npix; p++) begin
      if (poke && p == 5) start_a[s] = 1'b1;
      if (poke && p == 7) start_a[s] = 1'b0;
      feed_pixel(s, p, stall);
    end
    start_a[s] = 1'b0;
    wait_done(s, poke);
    if (poke) begin
      repeat (3) @(negedge clock);
      checks++;
      if (bsy(s) !== 1'b0) begin
        errors++;
        $display("FAIL %s start_on_done got busy=%b, required 0", tag, bsy(s));
      end
    end
    check_frame(s, tag);
  endtask

  task automatic test_reset;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (rdy(s) !== 1'b0 || dv(s) !== 1'b0 || bsy(s) !== 1'b0 || fdn(s) !== 1'b0 ||
          isr(s) !== 1'b0 || dat(s) !== 0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got rdy=%b dv=%b busy=%b done=%b isr=%b data=%0d, required all 0",
                 s, rdy(s), dv(s), bsy(s), fdn(s), isr(s), dat(s));
      end
    end
    checks++;
    if (winv0 !== 1'b0 || wr0 !== 2'd0 || wc0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_window got v=%b r=%0d c=%0d, required 0 0 0", winv0, wr0, wc0);
    end
    @(negedge clock);
    sreset_n = 1'b1;
    #1;
    checks++;
    if (ibsr0 !== 1'b0) begin
      errors++;
      $display("FAIL release_hold got ib_sreset_n=%b, required 0", ibsr0);
    end
    @(posedge clock); #1;
    checks++;
    if (ibsr0 !== 1'b1 || ibsr1 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL release_edge got isr=%b/%b busy=%b, required 1/1 0", ibsr0, ibsr1, busy0);
    end
  endtask

  task automatic test_reset_mid_frame;
    clear_stats(0);
    pulse_start(0);
    for (int p = 1; p <= 7; p++) feed_pixel(0, p, 1'b0);
    #2 sreset_n = 1'b0;
    #1;
    checks++;
    if (s_ready0 !== 1'b0 || ibv0 !== 1'b0 || busy0 !== 1'b0 || fd0 !== 1'b0 ||
        ibsr0 !== 1'b0 || ibd0 !== 8'd0 || winv0 !== 1'b0 || wr0 !== 2'd0 || wc0 !== 2'd0) begin
      errors++;
      $display("FAIL midreset_outputs got rdy=%b dv=%b busy=%b done=%b isr=%b data=%0d, required 0 0 0 0 0 0",
               s_ready0, ibv0, busy0, fd0, ibsr0, ibd0);
    end
    @(negedge clock);
    sreset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (ibsr0 !== 1'b1 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release got isr=%b busy=%b, required 1 0", ibsr0, busy0);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (fd_n[0] !== 0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_done got done=%0d busy=%b, required 0 0", fd_n[0], busy0);
    end
    run_frame(0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start_a[s] = 1'b0; s_valid_a[s] = 1'b0; s_data_a[s] = 8'd0;
    end
    test_reset;
    run_frame(0, 1'b0, 1'b0, "stride1");
    run_frame(1, 1'b0, 1'b0, "stride2");
    run_frame(0, 1'b1, 1'b0, "stall");
    run_frame(0, 1'b0, 1'b1, "start_ignored");
    test_reset_mid_frame;
    run_frame(0, 1'b0, 1'b0, "b2b_first");
    run_frame(0, 1'b0, 1'b0, "b2b_second");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
